// File: rtl/pipeline_sequencer_if.sv
// Host command/response channel of the pipeline sequencer.
// master = host side, slave = sequencer side.
interface pipeline_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// Host-side sequencer that loads, runs and inspects a pipeline core.
// Optional macro PIPELINE_SEQUENCER_CYCLE_COUNT_EN adds the run_cycles counter output.
module pipeline_sequencer #(
  parameter int READ_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_sequencer_if.slave  host,
  output logic                 busy,
  output logic                 start,
  output logic [31:0]          address,
  output logic [31:0]          instruction,
  output logic                 DataOrReg,
  output logic [31:0]          check_address,
`ifdef PIPELINE_SEQUENCER_CYCLE_COUNT_EN
  output logic [31:0]          run_cycles,
`endif
  input  logic [31:0]          value
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, PEEK, RESP} state_t;

  state_t      state;
  logic [31:0] count;

  assign busy           = (state != IDLE);
  assign host.cmd_ready = (state == IDLE) && !rst;

  // count is the RUN down-counter (0 = free run) and doubles as the PEEK latency timer
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      count         <= 32'd0;
      start         <= 1'b0;
      host.rsp_valid <= 1'b0;
      host.rsp_data <= 32'd0;
      address       <= 32'd0;
      instruction   <= 32'd0;
      check_address <= 32'd0;
      DataOrReg     <= 1'b0;
    end else begin
      host.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (host.cmd_valid) begin
            case (host.cmd_op)
              2'b00: begin
                address     <= host.cmd_addr;
                instruction <= host.cmd_data;
                state       <= LOAD;
              end
              2'b01: begin
                count <= host.cmd_data;
                start <= 1'b1;
                state <= RUN;
              end
              default: begin
                check_address <= host.cmd_op[0] ? host.cmd_addr
                                                : {27'd0, host.cmd_addr[4:0]};
                DataOrReg     <= host.cmd_op[0];
                count         <= 32'(READ_LAT);
                state         <= PEEK;
              end
            endcase
          end
        end
        LOAD: state <= IDLE;
        RUN: begin
          if (count == 32'd1) begin
            count <= 32'd0;
            start <= 1'b0;
            state <= IDLE;
          end else if (count != 32'd0) begin
            count <= count - 32'd1;
          end
        end
        PEEK: begin
          if (count <= 32'd1) begin
            host.rsp_data  <= value;
            host.rsp_valid <= 1'b1;
            count          <= 32'd0;
            state          <= RESP;
          end else begin
            count <= count - 32'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PIPELINE_SEQUENCER_CYCLE_COUNT_EN
  // Cleared on every RUN accept so it reports the length of the latest run
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cycles <= 32'd0;
    end else if (state == IDLE && host.cmd_valid && host.cmd_op == 2'b01) begin
      run_cycles <= 32'd0;
    end else if (start && run_cycles != 32'hFFFF_FFFF) begin
      run_cycles <= run_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed self-checking bench for pipeline_sequencer (READ_LAT = 3).
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_pipeline_sequencer;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy, start, DataOrReg;
  logic [31:0] address, instruction, check_address;
  logic [31:0] value;
`ifdef PIPELINE_SEQUENCER_CYCLE_COUNT_EN
  logic [31:0] run_cycles;
`endif

  int checks = 0;
  int fails  = 0;

  pipeline_sequencer_if bus ();

  pipeline_sequencer #(.READ_LAT(LAT)) dut (
    .clk           (clk),
    .rst           (rst),
    .host          (bus),
    .busy          (busy),
    .start         (start),
    .address       (address),
    .instruction   (instruction),
    .DataOrReg     (DataOrReg),
    .check_address (check_address),
`ifdef PIPELINE_SEQUENCER_CYCLE_COUNT_EN
    .run_cycles    (run_cycles),
`endif
    .value         (value)
  );

  always #5 clk = ~clk;

  // Pipeline model: inspected word becomes visible LAT-1 register stages after the address
  function automatic logic [31:0] peekModel(input logic [31:0] a, input logic dor);
    if (dor) return (a == 32'h100) ? 32'hCAFE_0100 : (32'h0BAD_0000 | a);
    else     return (a == 32'h1)   ? 32'hDEAD_BEEF : (32'h1000_0000 | a);
  endfunction

  logic [31:0] p0 = 32'd0;
  logic [31:0] p1 = 32'd0;
  always @(posedge clk) begin
    p0 <= peekModel(check_address, DataOrReg);
    p1 <= p0;
  end
  assign value = p1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Presents a command at a falling edge, waits for the handshake, returns at the
  // falling edge of the first cycle after the accept edge
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] d);
    int waited;
    waited        = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = a;
    bus.cmd_data  = d;
    #1;
    while (!bus.cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("handshake_ready", {31'd0, bus.cmd_ready}, 32'd1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_addr  = 32'd0;
    bus.cmd_data  = 32'd0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("ready_in_rst", {31'd0, bus.cmd_ready}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("ready_after_rst", {31'd0, bus.cmd_ready}, 32'd1);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_start", {31'd0, start}, 32'd0);
    checkOutput("rst_address", address, 32'd0);
    checkOutput("rst_instruction", instruction, 32'd0);
    checkOutput("rst_check_address", check_address, 32'd0);
    checkOutput("rst_dor", {31'd0, DataOrReg}, 32'd0);
    checkOutput("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    checkOutput("rst_rsp_data", bus.rsp_data, 32'd0);
    @(negedge clk);

    // LOAD
    applyStimulus(2'b00, 32'h8, 32'h0050_0093);
    checkOutput("load_address", address, 32'h8);
    checkOutput("load_instruction", instruction, 32'h0050_0093);
    checkOutput("load_start", {31'd0, start}, 32'd0);
    checkOutput("load_busy", {31'd0, busy}, 32'd1);
    checkOutput("load_ready_low", {31'd0, bus.cmd_ready}, 32'd0);
    checkOutput("load_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    checkOutput("load_ready_back", {31'd0, bus.cmd_ready}, 32'd1);

    // RUN 5
    applyStimulus(2'b01, 32'd0, 32'd5);
    for (int i = 1; i <= 5; i++) begin
      checkOutput($sformatf("run5_start_c%0d", i), {31'd0, start}, 32'd1);
      checkOutput($sformatf("run5_busy_c%0d", i), {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    checkOutput("run5_start_end", {31'd0, start}, 32'd0);
    checkOutput("run5_ready_end", {31'd0, bus.cmd_ready}, 32'd1);
`ifdef PIPELINE_SEQUENCER_CYCLE_COUNT_EN
    checkOutput("run5_cycles", run_cycles, 32'd5);
`endif

    // PEEK_REG 0x21 -> register 1
    applyStimulus(2'b10, 32'h21, 32'd0);
    checkOutput("peekreg_check_address", check_address, 32'h1);
    checkOutput("peekreg_dor", {31'd0, DataOrReg}, 32'd0);
    checkOutput("peekreg_start", {31'd0, start}, 32'd0);
    for (int i = 1; i <= LAT; i++) begin
      checkOutput($sformatf("peekreg_no_rsp_c%0d", i), {31'd0, bus.rsp_valid}, 32'd0);
      @(negedge clk);
    end
    checkOutput("peekreg_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    checkOutput("peekreg_rsp_data", bus.rsp_data, 32'hDEAD_BEEF);
    @(negedge clk);
    checkOutput("peekreg_pulse_end", {31'd0, bus.rsp_valid}, 32'd0);
    checkOutput("peekreg_data_hold", bus.rsp_data, 32'hDEAD_BEEF);
    checkOutput("peekreg_ready", {31'd0, bus.cmd_ready}, 32'd1);

    // PEEK_MEM 0x100
    applyStimulus(2'b11, 32'h100, 32'd0);
    checkOutput("peekmem_check_address", check_address, 32'h100);
    checkOutput("peekmem_dor", {31'd0, DataOrReg}, 32'd1);
    checkOutput("peekmem_address_hold", address, 32'h8);
    for (int i = 1; i <= LAT; i++) begin
      checkOutput($sformatf("peekmem_no_rsp_c%0d", i), {31'd0, bus.rsp_valid}, 32'd0);
      checkOutput($sformatf("peekmem_old_data_c%0d", i), bus.rsp_data, 32'hDEAD_BEEF);
      @(negedge clk);
    end
    checkOutput("peekmem_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    checkOutput("peekmem_rsp_data", bus.rsp_data, 32'hCAFE_0100);
    @(negedge clk);

    // RUN 1 boundary
    applyStimulus(2'b01, 32'd0, 32'd1);
    checkOutput("run1_start", {31'd0, start}, 32'd1);
    @(negedge clk);
    checkOutput("run1_start_end", {31'd0, start}, 32'd0);
    checkOutput("run1_busy_end", {31'd0, busy}, 32'd0);
    checkOutput("run1_dor_hold", {31'd0, DataOrReg}, 32'd1);

    // LOAD held during RUN 3 is only taken on the first IDLE cycle
    applyStimulus(2'b01, 32'd0, 32'd3);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b00;
    bus.cmd_addr  = 32'h40;
    bus.cmd_data  = 32'h1111_1111;
    for (int i = 1; i <= 3; i++) begin
      checkOutput($sformatf("hold_start_c%0d", i), {31'd0, start}, 32'd1);
      checkOutput($sformatf("hold_address_c%0d", i), address, 32'h8);
      @(negedge clk);
    end
    checkOutput("hold_idle_start", {31'd0, start}, 32'd0);
    checkOutput("hold_idle_ready", {31'd0, bus.cmd_ready}, 32'd1);
    checkOutput("hold_idle_address", address, 32'h8);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("hold_load_address", address, 32'h40);
    checkOutput("hold_load_instruction", instruction, 32'h1111_1111);
    checkOutput("hold_load_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);

    // Free run, then reset
    applyStimulus(2'b01, 32'd0, 32'd0);
    for (int i = 1; i <= 20; i++) begin
      checkOutput($sformatf("free_start_c%0d", i), {31'd0, start}, 32'd1);
      if (i < 20) @(negedge clk);
    end
`ifdef PIPELINE_SEQUENCER_CYCLE_COUNT_EN
    checkOutput("free_run_cycles", run_cycles, 32'd19);
`endif
    rst = 1'b1;
    #1;
    checkOutput("free_ready_in_rst", {31'd0, bus.cmd_ready}, 32'd0);
    @(negedge clk);
    checkOutput("free_rst_start", {31'd0, start}, 32'd0);
    checkOutput("free_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("free_rst_address", address, 32'd0);
    checkOutput("free_rst_instruction", instruction, 32'd0);
    checkOutput("free_rst_check_address", check_address, 32'd0);
    checkOutput("free_rst_dor", {31'd0, DataOrReg}, 32'd0);
    checkOutput("free_rst_rsp_data", bus.rsp_data, 32'd0);
    checkOutput("free_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
`ifdef PIPELINE_SEQUENCER_CYCLE_COUNT_EN
    checkOutput("free_rst_run_cycles", run_cycles, 32'd0);
`endif
    rst = 1'b0;
    #1;
    checkOutput("free_ready_after_rst", {31'd0, bus.cmd_ready}, 32'd1);
    @(negedge clk);

    // Reset in the middle of a PEEK aborts it with no response
    applyStimulus(2'b11, 32'h100, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_check_address", check_address, 32'd0);
    checkOutput("abort_dor", {31'd0, DataOrReg}, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      checkOutput($sformatf("abort_no_rsp_c%0d", i), {31'd0, bus.rsp_valid}, 32'd0);
      checkOutput($sformatf("abort_rsp_data_c%0d", i), bus.rsp_data, 32'd0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
